// File: rtl/lcd_serial_responder_if.sv
// lcd_serial_responder_if: 3-wire LCD serial link, local read port and write-report signals
interface lcd_serial_responder_if;
  logic       sclk;
  logic       cs_n;
  logic       sdi;
  logic       sdo;
  logic       sdo_en;
  logic [6:0] local_address;
  logic [7:0] local_data;
  logic       wr_strobe;
  logic [6:0] wr_address;
  logic [7:0] wr_data;
  logic       frame_error;
  modport master (
    output sclk, cs_n, sdi, local_address,
    input  sdo, sdo_en, local_data, wr_strobe, wr_address, wr_data, frame_error
  );
  modport slave (
    input  sclk, cs_n, sdi, local_address,
    output sdo, sdo_en, local_data, wr_strobe, wr_address, wr_data, frame_error
  );
endinterface

// File: rtl/lcd_serial_responder.sv
// lcd_serial_responder: oversampled LCD 3-wire serial target with 8-bit register bank.
// Define LCD_RESP_STATUS_EN to make address 7'h7F a read-only {frame_error_count, write_count} status register.
module lcd_serial_responder #(
  parameter int         REG_COUNT   = 16,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input logic clk,
  input logic rst,
  lcd_serial_responder_if.slave bus
);
  localparam int AW = REG_COUNT > 1 ? $clog2(REG_COUNT) : 1;
  localparam logic [7:0] RC = 8'(REG_COUNT);
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDRESS, S_WRDATA, S_RDDATA, S_COMMIT, S_WAITDESELECT
  } state_t;
  state_t state, state_nx;
  logic [1:0] sclk_q, cs_q, sdi_q;
  logic       sclk_p, armed, rw;
  logic [4:0] cnt;
  logic [6:0] addr, rd_a;
  logic [7:0] data, rd_shift, rd_val;
  logic [7:0] regs [2**AW];
  logic       rise, fall, cs, sdi, abort, commit, wr_ok, rd_ok;
  assign rise = sclk_q[1] & ~sclk_p;
  assign fall = ~sclk_q[1] & sclk_p;
  assign cs = cs_q[1];
  assign sdi = sdi_q[1];
  assign rd_a = {addr[5:0], sdi};
  assign rd_ok = {1'b0, rd_a} < RC;
  assign abort = cs && (state inside {S_CMD, S_ADDRESS, S_WRDATA, S_RDDATA});
  assign commit = !cs && rise && state == S_WRDATA && cnt == 5'd15 && wr_ok;
  assign bus.local_data = ({1'b0, bus.local_address} < RC) ? regs[bus.local_address[AW-1:0]] : 8'h00;
`ifdef LCD_RESP_STATUS_EN
  logic [3:0] fe_cnt, wr_cnt;
  assign wr_ok = ({1'b0, addr} < RC) && addr != 7'h7F;
  assign rd_val = rd_a == 7'h7F ? {fe_cnt, wr_cnt} : rd_ok ? regs[rd_a[AW-1:0]] : 8'h00;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fe_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (abort && fe_cnt != 4'hF) fe_cnt <= fe_cnt + 4'd1;
      if (commit) wr_cnt <= wr_cnt + 4'd1;
    end
`else
  assign wr_ok = {1'b0, addr} < RC;
  assign rd_val = rd_ok ? regs[rd_a[AW-1:0]] : 8'h00;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (!cs && armed) state_nx = S_CMD;
      S_CMD:     state_nx = cs ? S_IDLE : rise ? S_ADDRESS : S_CMD;
      S_ADDRESS: state_nx = cs ? S_IDLE : (rise && cnt == 5'd7) ? (rw ? S_RDDATA : S_WRDATA) : S_ADDRESS;
      S_WRDATA:  state_nx = cs ? S_IDLE : (rise && cnt == 5'd15) ? S_COMMIT : S_WRDATA;
      S_RDDATA:  state_nx = cs ? S_IDLE : (rise && cnt == 5'd15) ? S_WAITDESELECT : S_RDDATA;
      S_COMMIT:  state_nx = S_WAITDESELECT;
      default:   state_nx = cs ? S_IDLE : S_WAITDESELECT;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      {sclk_q, cs_q, sdi_q, sclk_p, armed, rw} <= '0;
      cnt <= '0;
      addr <= '0;
      data <= '0;
      rd_shift <= '0;
      bus.sdo <= 1'b0;
      bus.sdo_en <= 1'b0;
      bus.wr_strobe <= 1'b0;
      bus.wr_address <= '0;
      bus.wr_data <= '0;
      bus.frame_error <= 1'b0;
      for (int i = 0; i < 2**AW; i++) regs[i] <= RESET_VALUE;
    end else begin
      sclk_q <= {sclk_q[0], bus.sclk};
      cs_q <= {cs_q[0], bus.cs_n};
      sdi_q <= {sdi_q[0], bus.sdi};
      sclk_p <= sclk_q[1];
      armed <= armed | cs;
      state <= state_nx;
      bus.frame_error <= abort;
      bus.wr_strobe <= commit;
      if (state == S_IDLE) cnt <= '0;
      else if (rise && state inside {S_CMD, S_ADDRESS, S_WRDATA, S_RDDATA}) cnt <= cnt + 5'd1;
      if (rise && state == S_CMD) rw <= sdi;
      if (rise && state == S_ADDRESS) addr <= rd_a;
      if (rise && state == S_WRDATA) data <= {data[6:0], sdi};
      if (commit) begin
        regs[addr[AW-1:0]] <= {data[6:0], sdi};
        bus.wr_address <= addr;
        bus.wr_data <= {data[6:0], sdi};
      end
      // read data leaves on falling edges 8..15; falling edge 16 ends the hold of bit 0
      if (rise && state == S_ADDRESS && cnt == 5'd7) rd_shift <= rd_val;
      if (cs || (fall && state == S_WAITDESELECT)) begin
        bus.sdo <= 1'b0;
        bus.sdo_en <= 1'b0;
      end else if (fall && state == S_RDDATA) begin
        bus.sdo <= rd_shift[7];
        bus.sdo_en <= 1'b1;
        rd_shift <= {rd_shift[6:0], 1'b0};
      end
    end
endmodule

// File: tb/tb_lcd_serial_responder.sv
// tb_lcd_serial_responder: directed frames with a queue scoreboard checked by independent monitors
module tb_lcd_serial_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int fe_exp = 0;
  int rises = 0;
  int nbits = 0;
  bit rd_frame = 1'b0;
  bit strobe_q = 1'b0;
  logic [7:0] rbyte;
  logic [14:0] wq[$];
  logic [7:0] rq[$];
  lcd_serial_responder_if bus();
  lcd_serial_responder dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic frame(input bit rw, input logic [6:0] a, input logic [7:0] d, input int n, input int rst_at);
    logic [15:0] bits;
    bits = {rw, a, d};
    rd_frame = rw && n == 16 && rst_at == 0;
    bus.cs_n = 1'b0;
    #200;
    for (int i = 0; i < n; i++) begin
      bus.sdi = i < 16 ? bits[15-i] : 1'b1;
      #100 bus.sclk = 1'b1;
      if (rst_at == i + 1) begin
        #30 rst = 1'b1;
        #20 rst = 1'b0;
        #50;
      end else #100;
      bus.sclk = 1'b0;
    end
    #100;
    if (rd_frame) chk("sdo_en_after_fall16", bus.sdo_en, 0);
    #100 bus.cs_n = 1'b1;
    bus.sdi = 1'b0;
    #400;
    chk("sdo_en_deselected", bus.sdo_en, 0);
    rd_frame = 1'b0;
  endtask

  task automatic local_chk(input string name, input logic [6:0] a, input logic [7:0] exp);
    bus.local_address = a;
    #1 chk(name, bus.local_data, exp);
  endtask

  always @(negedge bus.cs_n) begin
    rises = 0;
    nbits = 0;
  end

  always @(posedge bus.sclk) if (!bus.cs_n) begin
    rises++;
    chk("sdo_en_phase", bus.sdo_en, rd_frame && rises >= 9 && rises <= 16);
    if (bus.sdo_en) begin
      rbyte = {rbyte[6:0], bus.sdo};
      nbits++;
      if (nbits == 8) begin
        if (rq.size() == 0) chk("unexpected_read", 1, 0);
        else chk("read_byte", rbyte, rq.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    logic [14:0] e;
    if (strobe_q) chk("strobe_width", bus.wr_strobe, 0);
    if (bus.wr_strobe) begin
      if (wq.size() == 0) chk("unexpected_strobe", 1, 0);
      else begin
        e = wq.pop_front();
        chk("wr_address", bus.wr_address, e[14:8]);
        chk("wr_data", bus.wr_data, e[7:0]);
      end
    end
    if (bus.frame_error) begin
      chk("frame_error_expected", fe_exp > 0, 1);
      if (fe_exp > 0) fe_exp--;
    end
    strobe_q = bus.wr_strobe;
  end

  initial begin
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.sdi = 1'b0;
    bus.local_address = 7'h05;
    #26;
    chk("rst_wr_strobe", bus.wr_strobe, 0);
    chk("rst_wr_address", bus.wr_address, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_frame_error", bus.frame_error, 0);
    chk("rst_sdo_en", bus.sdo_en, 0);
    chk("rst_sdo", bus.sdo, 0);
    chk("rst_local", bus.local_data, 0);
    #24 rst = 1'b0;
    #100;
    wq.push_back({7'h05, 8'hA5});
    frame(1'b0, 7'h05, 8'hA5, 16, 0);
    local_chk("local_05", 7'h05, 8'hA5);
    rq.push_back(8'hA5);
    frame(1'b1, 7'h05, 8'h00, 16, 0);
    frame(1'b0, 7'h20, 8'h3C, 16, 0);
    local_chk("local_20", 7'h20, 8'h00);
    rq.push_back(8'h00);
    frame(1'b1, 7'h20, 8'h00, 16, 0);
    fe_exp++;
    frame(1'b0, 7'h01, 8'h77, 10, 0);
    local_chk("local_01_aborted", 7'h01, 8'h00);
`ifdef LCD_RESP_STATUS_EN
    rq.push_back(8'h11);
    frame(1'b1, 7'h7F, 8'h00, 16, 0);
    frame(1'b0, 7'h7F, 8'h99, 16, 0);
    rq.push_back(8'h11);
    frame(1'b1, 7'h7F, 8'h00, 16, 0);
`endif
    frame(1'b0, 7'h02, 8'hAA, 16, 12);
    local_chk("local_02_reset_abort", 7'h02, 8'h00);
    local_chk("local_05_after_reset", 7'h05, 8'h00);
    wq.push_back({7'h02, 8'h55});
    frame(1'b0, 7'h02, 8'h55, 16, 0);
    local_chk("local_02", 7'h02, 8'h55);
    for (int i = 0; i < 6; i++) begin
      #100 bus.sclk = 1'b1;
      #100 bus.sclk = 1'b0;
    end
    #200;
    wq.push_back({7'h0F, 8'h5A});
    frame(1'b0, 7'h0F, 8'h5A, 16, 0);
    rq.push_back(8'h5A);
    frame(1'b1, 7'h0F, 8'h00, 16, 0);
    frame(1'b0, 7'h10, 8'hE1, 16, 0);
    wq.push_back({7'h03, 8'hC3});
    frame(1'b0, 7'h03, 8'hC3, 20, 0);
    local_chk("local_03_extra_edges", 7'h03, 8'hC3);
    local_chk("local_10", 7'h10, 8'h00);
    #500;
    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    chk("fe_pending", fe_exp, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
